// File: rtl/shift_piso_tx_if.sv
// Load handshake and serial output bundle for the PISO transmitter.
interface shift_piso_tx_if #(
  parameter int WIDTH = 8
);
  logic             load;
  logic [WIDTH-1:0] d_in;
  logic             ready;
  logic             s_out;
  logic             s_valid;
  logic             done;

  // Producer side: issues loads, watches the serial stream.
  modport master (
    output load, d_in,
    input  ready, s_out, s_valid, done
  );

  // Transmitter side.
  modport slave (
    input  load, d_in,
    output ready, s_out, s_valid, done
  );
endinterface

// File: rtl/shift_piso_tx.sv
// Parallel-in serial-out transmitter: accepts a byte on load/ready and
// shifts it out LSB-first, holding each bit for DIV clk cycles.
module shift_piso_tx #(
  parameter int WIDTH = 8,
  parameter int DIV   = 1,
  parameter int CW    = 16
) (
  input  logic            clk,
  input  logic            reset,
  shift_piso_tx_if.slave  bus
);
  localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_DIV = CW'(DIV - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]    div_cnt_q, div_cnt_d;
  logic             done_q, done_d;

  // State register; reset aborts any frame without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sh_q      <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      done_q    <= done_d;
    end
  end

  // Next-state: load in IDLE, hold/shift pacing in SHIFT; done self-clears.
  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          sh_d      = bus.d_in;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (div_cnt_q != LAST_DIV) begin
          div_cnt_d = div_cnt_q + 1'b1;
        end else begin
          div_cnt_d = '0;
          if (bit_cnt_q != LAST_BIT) begin
            sh_d      = {1'b0, sh_q[WIDTH-1:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
            sh_d    = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from registers only; nothing combinational from load/d_in.
  assign bus.ready   = (state_q == IDLE);
  assign bus.s_valid = (state_q == SHIFT);
  assign bus.s_out   = (state_q == SHIFT) & sh_q[0];
  assign bus.done    = done_q;
endmodule

// File: tb/tb_shift_piso_tx.sv
// Directed bench for shift_piso_tx: one DIV=1 and one DIV=3 instance,
// plus a negedge SIPO receiver looped back from the DIV=1 stream.
module tb_shift_piso_tx;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] sipo = 8'h00;
  logic [7:0] v;

  shift_piso_tx_if #(.WIDTH(8)) if1 ();
  shift_piso_tx_if #(.WIDTH(8)) if3 ();

  shift_piso_tx #(.WIDTH(8), .DIV(1), .CW(16)) dut1 (
    .clk(clk), .reset(reset), .bus(if1));
  shift_piso_tx #(.WIDTH(8), .DIV(3), .CW(16)) dut3 (
    .clk(clk), .reset(reset), .bus(if3));

  always #5 clk = ~clk;

  // Receiver model: shifts s_out in at the MSB on every falling edge.
  always @(negedge clk) sipo <= {if1.s_out, sipo[7:1]};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle1(input string tag);
    chk({tag, ".ready"},   8'(if1.ready),   8'h1);
    chk({tag, ".s_valid"}, 8'(if1.s_valid), 8'h0);
    chk({tag, ".s_out"},   8'(if1.s_out),   8'h0);
  endtask

  initial begin
    reset = 1'b1;
    if1.load = 1'b1; if1.d_in = 8'hFF;
    if3.load = 1'b1; if3.d_in = 8'hFF;

    // Reset with load held high: nothing may start.
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_idle1("rst");
      chk("rst.done", 8'(if1.done), 8'h0);
      chk("rst3.ready", 8'(if3.ready), 8'h1);
      chk("rst3.s_valid", 8'(if3.s_valid), 8'h0);
    end
    reset = 1'b0;
    if1.load = 1'b0; if3.load = 1'b0;
    tick();
    chk_idle1("post_rst");
    chk("post_rst3.ready", 8'(if3.ready), 8'h1);

    // Single frame DIV=1, 8'hA5.
    v = 8'hA5;
    if1.load = 1'b1; if1.d_in = v;
    tick();
    if1.load = 1'b0; if1.d_in = 8'h00;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("a5.s_out%0d", i), 8'(if1.s_out), 8'(v[i]));
      chk($sformatf("a5.s_valid%0d", i), 8'(if1.s_valid), 8'h1);
      chk($sformatf("a5.done%0d", i), 8'(if1.done), 8'h0);
      tick();
    end
    chk("a5.done8", 8'(if1.done), 8'h1);
    chk_idle1("a5.c8");
    tick();
    chk("a5.done9", 8'(if1.done), 8'h0);

    // Hold count DIV=3, 8'h01.
    if3.load = 1'b1; if3.d_in = 8'h01;
    tick();
    if3.load = 1'b0;
    for (int i = 0; i < 24; i++) begin
      chk($sformatf("div3.s_out%0d", i), 8'(if3.s_out), (i < 3) ? 8'h1 : 8'h0);
      chk($sformatf("div3.ready%0d", i), 8'(if3.ready), 8'h0);
      chk($sformatf("div3.done%0d", i), 8'(if3.done), 8'h0);
      tick();
    end
    chk("div3.done24", 8'(if3.done), 8'h1);
    chk("div3.ready24", 8'(if3.ready), 8'h1);
    tick();

    // Load while busy: 8'hF0 offered during cycle 3 must be ignored.
    v = 8'h0F;
    if1.load = 1'b1; if1.d_in = v;
    tick();
    if1.load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin if1.load = 1'b1; if1.d_in = 8'hF0; end
      if (i == 4) if1.load = 1'b0;
      chk($sformatf("busy.s_out%0d", i), 8'(if1.s_out), 8'(v[i]));
      chk($sformatf("busy.ready%0d", i), 8'(if1.ready), 8'h0);
      tick();
    end
    chk("busy.done8", 8'(if1.done), 8'h1);
    chk("busy.ready8", 8'(if1.ready), 8'h1);
    tick();
    chk_idle1("busy.c9");

    // Back-to-back: load held high, second frame accepted on the done cycle.
    if1.load = 1'b1; if1.d_in = 8'h81;
    tick();
    if1.d_in = 8'h7E;
    v = 8'h81;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("b2b.f1.s_out%0d", i), 8'(if1.s_out), 8'(v[i]));
      tick();
    end
    chk("b2b.gap.done", 8'(if1.done), 8'h1);
    chk_idle1("b2b.gap");
    tick();
    if1.load = 1'b0;
    v = 8'h7E;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("b2b.f2.s_out%0d", i), 8'(if1.s_out), 8'(v[i]));
      chk($sformatf("b2b.f2.s_valid%0d", i), 8'(if1.s_valid), 8'h1);
      tick();
    end
    chk("b2b.f2.done", 8'(if1.done), 8'h1);
    tick();

    // Loopback into the SIPO model.
    if1.load = 1'b1; if1.d_in = 8'h3C;
    tick();
    if1.load = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("loop.sipo_3c", sipo, 8'h3C);
    chk("loop.done", 8'(if1.done), 8'h1);
    tick();

    // Restart with 8'hC3, reset raised in cycle 4.
    if1.load = 1'b1; if1.d_in = 8'hC3;
    tick();
    if1.load = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    tick();
    chk_idle1("abort");
    chk("abort.done", 8'(if1.done), 8'h0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("abort.no_done%0d", i), 8'(if1.done), 8'h0);
      chk($sformatf("abort.s_valid%0d", i), 8'(if1.s_valid), 8'h0);
    end

    if1.load = 1'b1; if1.d_in = 8'hC3;
    tick();
    if1.load = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("retry.sipo_c3", sipo, 8'hC3);
    chk("retry.done", 8'(if1.done), 8'h1);
    tick();
    chk("retry.done_clr", 8'(if1.done), 8'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_piso_tx.md
# shift_piso_tx

Parallel-in serial-out transmitter: the sending end of the serial link whose receiver is the 8-bit serial-in parallel-out LED shift register. It accepts a parallel byte on a load handshake and shifts it out LSB-first, one bit per bit period. This ordering makes the SIPO receiver hold the original byte after WIDTH of its shifts. A programmable per-bit hold count slows the stream to a visible LED stepping rate.

## Interface
- WIDTH, 8: frame length in bits; must be ≥ 2.
- DIV, 1: clk cycles each bit is held on s_out; must be ≥ 1.
- CW, 16: width of the hold counter; must satisfy 2^CW ≥ DIV.

- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- load  in  1  request to send d_in; accepted only when ready=1.
- d_in  in  WIDTH  parallel data, sampled on the accepting edge.
- ready  out  1  transmitter idle; can accept load.
- s_out  out  1  serial data; connects to the receiver's s_in.
- s_valid  out  1  high while s_out carries a frame bit.
- done  out  1  one-cycle pulse after the last bit period ends.

## Operation
- Registered state: FSM state (IDLE, SHIFT), shift register sh[WIDTH-1:0], bit counter bit_cnt (0..WIDTH-1), hold counter div_cnt (0..DIV-1), done flag.
- Reset values, taking effect at the first edge with reset=1: state=IDLE, sh=0, bit_cnt=0, div_cnt=0, done=0. This makes ready=1, s_out=0, s_valid=0, done=0.
- Output decode:
  - ready = (state==IDLE).
  - s_valid = (state==SHIFT).
  - s_out = sh[0] in SHIFT; s_out = 0 in IDLE.
- IDLE:
  - On a rising edge with load=1: sh←d_in, bit_cnt←0, div_cnt←0, state←SHIFT.
  - load=0: state holds.
- SHIFT, where div_cnt < DIV-1: div_cnt increments; sh and bit_cnt hold.
- SHIFT, where div_cnt == DIV-1:
  - div_cnt←0.
  - If bit_cnt < WIDTH-1: sh←{1'b0, sh[WIDTH-1:1]}, bit_cnt increments.
  - If bit_cnt == WIDTH-1: state←IDLE, done←1, sh←0.
- done is cleared on every edge where it was not just set, so it is exactly one cycle wide.
- load is ignored while in SHIFT; d_in is don't-care outside the accepting edge.
- The done cycle is an IDLE cycle (ready=1). A load in that cycle is accepted, which gives back-to-back frames separated by exactly one idle cycle.
- reset=1 in any state aborts the frame immediately. No done pulse is produced; reset has priority over load.

## Timing
- Edge numbering: the accepting edge is edge 0. Cycle n means the interval after edge n.
- Bit i (LSB first) appears on s_out during cycles i·DIV … i·DIV+DIV-1.
- s_valid is high during cycles 0 … WIDTH·DIV-1.
- done=1 and ready=1 during cycle WIDTH·DIV.
- Frame period with continuous load: WIDTH·DIV+1 cycles.
- s_out changes only on rising edges. A receiver sampling on the falling edge sees it stable for a half cycle of setup.
- Pairing with the negedge SIPO: for DIV=1 with the SIPO on the same clk, the SIPO's r_reg equals the sent byte after the falling edge inside cycle WIDTH-1.
- No combinational path from load or d_in to any output.

## Test plan
- Reset: assert reset for 2 cycles with load=1 and d_in=8'hFF. Required: ready=1, s_out=0, s_valid=0, done=0 in every cycle after the first reset edge, and no frame starts.
- Single frame, DIV=1: load 8'hA5. Required: s_out in cycles 0–7 = 1,0,1,0,0,1,0,1; s_valid=1 in cycles 0–7; done=1 only in cycle 8.
- Hold count, DIV=3: load 8'h01. Required: s_out=1 in cycles 0–2, 0 in cycles 3–23; done in cycle 24; ready=0 in cycles 0–23.
- Load while busy: load 8'h0F, then pulse load with 8'hF0 in cycle 3. Required: the second load is ignored; the output stream is 1,1,1,1,0,0,0,0; ready stays 0 until cycle 8.
- Back-to-back: hold load=1 with 8'h81, then 8'h7E. Required: the second frame starts at edge 9 (the done cycle). s_out = 1,0,0,0,0,0,0,1, then one idle cycle, then 0,1,1,1,1,1,1,0.
- Reset mid-frame plus loopback: drive a negedge SIPO from s_out and load 8'h3C. Required: SIPO q_out=8'h3C after cycle 7. Then restart with 8'hC3 and assert reset in cycle 4. Required: outputs return to reset values at that edge, no done pulse occurs, and the next load of 8'hC3 completes normally.
